tl_ul_regfile_responder: RTL
============================

Name: tl_ul_regfile_responder

Overview:
TileLink-UL responder (slave end) serving a small word-addressed register file; the D-channel counterpart to the A-channel legality monitors on the same link. Accepts Get/PutFullData/PutPartialData on channel A and returns AccessAckData/AccessAck on channel D through an in-order response queue. Sits behind a TL-UL crossbar port; no burst support (single-beat only).

Parameters:
ADDR_W, 30, channel A address width
SRC_W, 5, source ID width
NUM_WORDS, 8, 32-bit registers in file (power of 2, 2..64)
BASE_ADDR, 30'h0, byte base address of the file (aligned to NUM_WORDS*4)
RSP_DEPTH, 2, response queue depth (power of 2, 1..4)

Ports:
clock  in  1  clock
reset_n  in  1  async active-low reset
a_valid  in  1  request valid
a_ready  out  1  request ready
a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get
a_param  in  3  must be 0
a_size  in  2  log2 bytes
a_source  in  SRC_W  requester ID
a_address  in  ADDR_W  byte address
a_mask  in  4  byte lanes
a_data  in  32  write data
d_valid  out  1  response valid
d_ready  in  1  response ready
d_opcode  out  3  0=AccessAck, 1=AccessAckData
d_param  out  2  always 0
d_size  out  2  echoes a_size
d_source  out  SRC_W  echoes a_source
d_denied  out  1  request rejected
d_data  out  32  read data, 0 for AccessAck
d_corrupt  out  1  equals d_denied on AccessAckData, else 0

Behaviour:
- Clock is clock; reset is reset_n, asynchronous assert, synchronous deassert handled upstream; active-low.
- Reset: register file all 0, queue empty; a_ready=0 only while reset_n low, then 1; d_valid=0, all d_* fields 0.
- Accept on a_valid & a_ready. a_ready = (count < RSP_DEPTH); no combinational path d_ready->a_ready.
- Word index = (a_address - BASE_ADDR)[log2(NUM_WORDS)+1:2]. In range iff a_address within [BASE_ADDR, BASE_ADDR+NUM_WORDS*4).
- Put accepted and legal: write bytes where a_mask[i]=1 at the accepting edge. PutFull uses mask as given.
- Get accepted and legal: read word sampled at accepting edge (after any earlier accepted write; a Put accepted in cycle N is visible to a Get accepted in cycle N+1).
- Response entry {opcode, size, source, denied, data} enqueued same edge; d_valid asserts the following cycle (1-cycle min latency). Responses strictly in acceptance order.
- Dequeue on d_valid & d_ready; d_* held stable while d_valid & ~d_ready.
- Simultaneous enqueue+dequeue: count unchanged, both happen. Full: a_ready=0 that cycle even if d_ready=1 (next cycle reopens).
- Pointers wrap modulo RSP_DEPTH; count is log2(RSP_DEPTH)+1 bits.
- Reset mid-operation: queue flushed, in-flight responses dropped, registers cleared.

Optional Feature:
Macro TL_RSP_ERR_CHECK_EN.
- Defined: request is illegal if opcode not in {0,1,4}, a_param!=0, a_size>2, address out of range, address misaligned to a_size, or PutFull mask not matching size/offset. Illegal request: no register write; response d_denied=1, d_opcode=1 for Get else 0, d_data=0, d_corrupt=1 for Get. Unknown opcodes answered with AccessAck denied.
- Not defined: no checks; d_denied=d_corrupt=0 always; out-of-range index truncated (aliases); unknown opcodes treated as Get.

Test Plan:
- Reset then PutFull addr BASE+0x4 data 0xDEADBEEF mask 0xF src 3 -> next cycle d_valid, AccessAck, d_source=3, d_data=0; Get 0x4 -> AccessAckData 0xDEADBEEF.
- PutPartial mask 0x2 data 0x0000AA00 to word 1 -> subsequent Get returns 0xDEADAABE F-> 0xDEADAAEF.
- Hold d_ready=0, issue 3 Gets back-to-back -> a_ready drops after 2 accepts, d_* stable; release d_ready -> responses in order, third request accepted the cycle after first dequeue.
- Put then Get in consecutive cycles same word, d_ready=1 -> Get returns new data; throughput 1/cycle with count steady at 1.
- With TL_RSP_ERR_CHECK_EN: Get addr BASE+NUM_WORDS*4 -> d_denied=1, d_corrupt=1, d_data=0; opcode 2 -> AccessAck denied, register file unchanged.
- Assert reset_n low with 2 responses queued -> d_valid=0 immediately, post-reset Get of any word returns 0.

Source files
------------

// File: rtl/tl_ul_regfile_responder.sv
// TileLink-UL responder: single-beat Get/PutFull/PutPartial on a word register file,
// answered in acceptance order from a RSP_DEPTH-entry queue. Optional macro: TL_RSP_ERR_CHECK_EN.
module tl_ul_regfile_responder #(
  parameter int unsigned       ADDR_W    = 30,
  parameter int unsigned       SRC_W     = 5,
  parameter int unsigned       NUM_WORDS = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       RSP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [1:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [3:0]        a_mask,
  input  logic [31:0]       a_data,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_param,
  output logic [1:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_denied,
  output logic [31:0]       d_data,
  output logic              d_corrupt
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

  typedef enum logic [2:0] {
    OP_PUT_FULL = 3'd0,
    OP_PUT_PART = 3'd1,
    OP_GET      = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    OP_ACK      = 3'd0,
    OP_ACK_DATA = 3'd1
  } d_op_e;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [1:0]       size;
    logic [SRC_W-1:0] source;
    logic             denied;
    logic [31:0]      data;
  } rsp_t;

  logic [31:0]       r_regs [NUM_WORDS];
  rsp_t              r_q    [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_is_put, w_get, w_legal;
  logic              w_acc, w_deq;
  rsp_t              w_rsp, w_head;

  assign w_off    = a_address - BASE_ADDR;
  assign w_idx    = w_off[IDX_W+1:2];
  assign w_is_put = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);

`ifdef TL_RSP_ERR_CHECK_EN
  logic       w_in_range, w_misalign;
  logic [3:0] w_full_mask;

  // Offset wraps below BASE_ADDR, so one unsigned compare covers both bounds.
  always_comb begin
    w_in_range = (w_off < ADDR_W'(NUM_WORDS * 4));
    w_misalign = ((a_size == 2'd1) && a_address[0]) ||
                 ((a_size == 2'd2) && (a_address[1:0] != 2'b00));
    case (a_size)
      2'd0:    w_full_mask = 4'b0001 << a_address[1:0];
      2'd1:    w_full_mask = 4'b0011 << {a_address[1], 1'b0};
      default: w_full_mask = 4'b1111;
    endcase
    w_get   = (a_opcode == OP_GET);
    w_legal = (w_is_put || w_get) && (a_param == 3'd0) && (a_size != 2'd3) &&
              w_in_range && !w_misalign &&
              !((a_opcode == OP_PUT_FULL) && (a_mask != w_full_mask));
  end
`else
  logic w_unused;
  assign w_get    = !w_is_put;
  assign w_legal  = 1'b1;
  assign w_unused = ^{a_param, w_off};
`endif

  assign a_ready = reset_n && (r_count < CNT_W'(RSP_DEPTH));
  assign w_acc   = a_valid && a_ready;
  assign d_valid = (r_count != '0);
  assign w_deq   = d_valid && d_ready;

  always_comb begin
    w_rsp        = '0;
    w_rsp.size   = a_size;
    w_rsp.source = a_source;
    w_rsp.denied = !w_legal;
    if (!w_legal) begin
      w_rsp.opcode = (a_opcode == OP_GET) ? OP_ACK_DATA : OP_ACK;
    end else if (w_get) begin
      w_rsp.opcode = OP_ACK_DATA;
      w_rsp.data   = r_regs[w_idx];
    end else begin
      w_rsp.opcode = OP_ACK;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) r_regs[i] <= '0;
    end else if (w_acc && w_legal && w_is_put) begin
      for (int unsigned b = 0; b < 4; b++)
        if (a_mask[b]) r_regs[w_idx][8*b +: 8] <= a_data[8*b +: 8];
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < RSP_DEPTH; i++) r_q[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_acc) begin
        r_q[r_wr_ptr] <= w_rsp;
        r_wr_ptr      <= ptr_inc(r_wr_ptr);
      end
      if (w_deq) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_acc, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Popped entries linger in storage; gate so an empty queue drives all-zero fields.
  assign w_head    = d_valid ? r_q[r_rd_ptr] : '0;
  assign d_opcode  = w_head.opcode;
  assign d_param   = '0;
  assign d_size    = w_head.size;
  assign d_source  = w_head.source;
  assign d_denied  = w_head.denied;
  assign d_data    = w_head.data;
  assign d_corrupt = w_head.denied && (w_head.opcode == OP_ACK_DATA);

endmodule
